// File: rtl/adder_tree_pkg.sv
// Shared types and defaults for the adder tree operand feeder.
// Holds the FSM state encoding and the counter width helper.
package adder_tree_pkg;
  localparam int DATA_W_DEF   = 15;
  localparam int RES_W_DEF    = 16;
  localparam int N_OPS_DEF    = 8;
  localparam int TREE_LAT_DEF = 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WAIT    = 2'd1,
    RESULT  = 2'd2
  } state_e;

  // Index width for a counter spanning 0..n-1; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/adder_tree_slot_bank.sv
// Write-indexed operand bank feeding the tree leaves.
// Slot k appears at leaf_ops_o[k*DATA_W +: DATA_W].
module adder_tree_slot_bank
  import adder_tree_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_OPS  = N_OPS_DEF,
  parameter int IW     = cnt_w(N_OPS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we_i,
  input  logic [IW-1:0]           widx_i,
  input  logic [DATA_W-1:0]       wdata_i,
  output logic [N_OPS*DATA_W-1:0] leaf_ops_o
);

  logic [N_OPS-1:0][DATA_W-1:0] slot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else if (we_i) begin
      for (int k = 0; k < N_OPS; k++) begin
        if (widx_i == IW'(k)) slot_q[k] <= wdata_i;
      end
    end
  end

  assign leaf_ops_o = slot_q;

endmodule

// File: rtl/adder_tree_feeder.sv
// Serial-to-parallel front end for the adder tree: gathers N_OPS operands,
// waits out the tree latency, and returns the captured sum on a result stream.
module adder_tree_feeder
  import adder_tree_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int N_OPS    = N_OPS_DEF,
  parameter int TREE_LAT = TREE_LAT_DEF,
  parameter int RES_W    = RES_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic [N_OPS*DATA_W-1:0] leaf_ops,
  input  logic [RES_W-1:0]        tree_sum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RES_W-1:0]        out_sum,
  output logic                    busy
);

  localparam int CW  = cnt_w(N_OPS);
  localparam int WCW = cnt_w(TREE_LAT + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             ov_q, ov_d;
  logic [RES_W-1:0] sum_q, sum_d;
  logic             we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      ov_q    <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      ov_q    <= ov_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    ov_d    = ov_q;
    sum_d   = sum_q;
    we      = 1'b0;
    if (clr) begin
      // Abort drops any in-flight tree sum; leaf slots are left as they are.
      state_d = COLLECT;
      cnt_d   = '0;
      wcnt_d  = '0;
      ov_d    = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_valid) begin
            we = 1'b1;
            if (cnt_q == CW'(N_OPS - 1)) begin
              cnt_d   = '0;
              wcnt_d  = WCW'(TREE_LAT);
              state_d = WAIT;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        WAIT: begin
          // Zero is seen one edge after the last decrement: TREE_LAT+1 edges total.
          if (wcnt_q == '0) begin
            sum_d   = tree_sum;
            ov_d    = 1'b1;
            state_d = RESULT;
          end else begin
            wcnt_d = wcnt_q - WCW'(1);
          end
        end
        RESULT: begin
          if (out_ready) begin
            ov_d    = 1'b0;
            state_d = COLLECT;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  adder_tree_slot_bank #(
    .DATA_W (DATA_W),
    .N_OPS  (N_OPS),
    .IW     (CW)
  ) u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (we),
    .widx_i     (cnt_q),
    .wdata_i    (in_data),
    .leaf_ops_o (leaf_ops)
  );

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = ov_q;
  assign out_sum   = sum_q;
  assign busy      = !((state_q == COLLECT) && (cnt_q == '0));

endmodule

// File: tb/tb_adder_tree_feeder.sv
// Bench for adder_tree_feeder: random operand groups against a sum-of-operands
// reference, plus abort, backpressure and async reset scenarios.
module tb_adder_tree_feeder;
  localparam int DW  = 15;
  localparam int RW  = 16;
  localparam int N   = 8;
  localparam int LAT = 2;

  logic            clk, rst_n, clr, in_valid, in_ready, out_valid, out_ready, busy;
  logic [DW-1:0]   in_data;
  logic [N*DW-1:0] leaf_ops;
  logic [RW-1:0]   tree_sum, out_sum, s1;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] grp [N];

  adder_tree_feeder #(.DATA_W(DW), .N_OPS(N), .TREE_LAT(LAT), .RES_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .leaf_ops(leaf_ops), .tree_sum(tree_sum), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-register adder tree stand-in: leaf sum register, then output register.
  function automatic logic [RW-1:0] leaf_total(input logic [N*DW-1:0] v);
    logic [RW-1:0] s = '0;
    for (int k = 0; k < N; k++) s = s + RW'(v[k*DW +: DW]);
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      tree_sum <= '0;
    end else begin
      s1       <= leaf_total(leaf_ops);
      tree_sum <= s1;
    end
  end

  function automatic int model_sum();
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(grp[k]);
    return s % 65536;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer one operand at pct% duty; returns just after the accepting edge.
  task automatic send_op(input logic [DW-1:0] d, input int pct);
    bit xfer;
    int guard = 0;
    do begin
      in_valid = ($urandom_range(99) < pct);
      in_data  = in_valid ? d : DW'($urandom);
      @(negedge clk);
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!xfer && guard < 200);
    if (!xfer) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_all(input int pct);
    for (int k = 0; k < N; k++) send_op(grp[k], pct);
  endtask

  // Wait for the result, check latency/value/slots, hold off for `hold` cycles, accept.
  task automatic wait_result(input int hold);
    int edges = 0;
    logic [RW-1:0] exp = RW'(model_sum());
    out_ready = (hold == 0);
    @(negedge clk);
    for (int k = 0; k < N; k++) chk($sformatf("slot%0d", k), 32'(leaf_ops[k*DW +: DW]), 32'(grp[k]));
    while (!out_valid && edges < 50) begin
      chk("wait_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
      edges++;
      @(negedge clk);
    end
    chk("latency", edges, LAT + 1);
    chk("sum", 32'(out_sum), 32'(exp));
    chk("res_in_ready", 32'(in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_sum", 32'(out_sum), 32'(exp));
      chk("hold_in_ready", 32'(in_ready), 0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("acc_valid", 32'(out_valid), 1);
      chk("acc_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_valid", 32'(out_valid), 0);
    chk("post_in_ready", 32'(in_ready), 1);
    chk("post_busy", 32'(busy), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_leaf", 32'(leaf_ops == '0), 1);
    @(posedge clk); #1;

    // Operands 1..8 -> 36
    for (int k = 0; k < N; k++) grp[k] = DW'(k + 1);
    send_all(100);
    wait_result(0);

    // All max operands -> 0xFFF8
    for (int k = 0; k < N; k++) grp[k] = 15'h7FFF;
    send_all(100);
    wait_result(0);

    // Backpressure for 5 cycles, then group of ones
    for (int k = 0; k < N; k++) grp[k] = DW'($urandom);
    send_all(100);
    wait_result(5);
    for (int k = 0; k < N; k++) grp[k] = 15'd1;
    send_all(100);
    wait_result(0);

    // Bubbles at 30% duty: 10,20,...,80 -> 360
    for (int k = 0; k < N; k++) grp[k] = DW'(10 * (k + 1));
    send_all(30);
    wait_result(0);

    // Abort after 5 operands; the clr-cycle transfer is discarded
    for (int k = 0; k < 5; k++) send_op(DW'(100 + k), 100);
    @(negedge clk);
    chk("part_busy", 32'(busy), 1);
    @(posedge clk); #1;
    clr = 1'b1; in_valid = 1'b1; in_data = 15'd99;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) grp[k] = 15'd2;
    send_all(100);
    wait_result(0);

    // Abort during WAIT: no result appears, slots untouched
    for (int k = 0; k < N; k++) grp[k] = DW'($urandom);
    send_all(100);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("clrw_valid", 32'(out_valid), 0);
      chk("clrw_busy", 32'(busy), 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("clrw_slot7", 32'(leaf_ops[7*DW +: DW]), 32'(grp[7]));
    @(posedge clk); #1;

    // Random groups with random duty and backpressure
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < N; k++) grp[k] = DW'($urandom);
      send_all(int'($urandom_range(30, 100)));
      wait_result(int'($urandom_range(0, 4)));
    end

    // Async reset mid-WAIT
    for (int k = 0; k < N; k++) grp[k] = DW'($urandom);
    send_all(100);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_leaf", 32'(leaf_ops == '0), 1);
    chk("arst_busy", 32'(busy), 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) grp[k] = 15'd3;
    send_all(100);
    wait_result(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_tree_feeder.md
Name: adder_tree_feeder

Overview:
- Streaming front/back end for the 8-leaf adder tree top.
- Accepts operands one per handshake, deserialises 8 of them into a parallel bank, and drives the tree's eight leaf inputs.
- Waits the tree's fixed pipeline latency, captures the tree's sum and returns it on a valid/ready result stream.
- Sits between a serial operand producer and the adder tree top; one group in flight at a time.

Parameters:
- DATA_W, 15, operand width (equals the tree's ADDER_WIDTH).
- N_OPS, 8, operands per group (tree leaf count); must be a power of 2, at least 2.
- TREE_LAT, 2, clock edges from leaf inputs stable to tree sum valid (input register plus sum register).
- RES_W, 16, width of the tree sum port and of the result (DATA_W+1).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous abort: drop the partial group or pending result
- in_valid  in  1  operand valid
- in_ready  out  1  operand ready
- in_data  in  DATA_W  operand
- leaf_ops  out  N_OPS*DATA_W  to tree leaf inputs; slot k at bits [k*DATA_W +: DATA_W]
- tree_sum  in  RES_W  from tree sum output
- out_valid  out  1  result valid
- out_ready  in  1  result ready
- out_sum  out  RES_W  captured sum
- busy  out  1  high in any state other than COLLECT with count 0

Behaviour:
- Reset (rst_n low, async):
  - state=COLLECT, count=0, leaf_ops=0, out_sum=0, out_valid=0, wait counter=0.
  - in_ready=1 on the first cycle after release.
- State machine:
  - COLLECT: in_ready=1. Each in_valid&in_ready writes in_data into slot[count] and increments count. The transfer writing slot N_OPS-1 moves to WAIT, resets count to 0 and loads wait counter = TREE_LAT.
  - WAIT: in_ready=0; leaf_ops held stable. Wait counter decrements each cycle. When it reaches 0, register tree_sum into out_sum, set out_valid=1, go to RESULT. Capture occurs TREE_LAT+1 edges after the last operand transfer.
  - RESULT: out_valid=1, out_sum stable. On out_valid&out_ready: out_valid=0, go to COLLECT.
- No bypass: in_ready stays 0 in RESULT, even during the accept cycle. The next group starts the cycle after.
- Slots are filled in arrival order, slot 0 first. Slots not written in the current group keep their old values, but are always fully overwritten before WAIT.
- clr:
  - Wins over every other event in the same cycle; an in_valid transfer in that cycle is discarded.
  - Returns to COLLECT with count=0 and out_valid=0; leaf_ops is left unchanged.
  - A tree sum in flight is ignored.
- in_valid while in_ready=0: held off; the producer must hold data.
- out_sum is captured verbatim; no widening or saturation. Any overflow of the RES_W-bit tree sum is the tree's concern. The model result is (sum of operands) mod 2^RES_W.
- in_data is don't-care when in_valid=0; no X may reach slots.
- Throughput: one result per N_OPS + TREE_LAT + 2 cycles minimum.

Decomposition:
- Shared package adder_tree_pkg:
  - DATA_W/RES_W defaults.
  - State enum {COLLECT, WAIT, RESULT}.
  - Function clog2-based count width.
- One sub-module, adder_tree_slot_bank: N_OPS-entry write-indexed register bank with flat leaf_ops output.
- FSM and counters stay in the top.

Test Plan:
- Operands 1..8, out_ready=1, tree model with TREE_LAT=2 -> out_sum=36 (0x0024). out_valid rises exactly 3 edges after the 8th transfer; in_ready=0 from the transfer until the cycle after acceptance.
- All operands 0x7FFF -> out_sum=0xFFF8 (262136 mod 65536); out_valid pulse length 1 with out_ready=1.
- Backpressure: result ready, out_ready low for 5 cycles -> out_sum stable, out_valid held, in_ready=0 throughout; group 2 (8x1) then yields 8.
- Bubbles: in_valid randomly toggled at 30% duty over 8 operands 10,20,...,80 -> 360; slot k holds 10*(k+1).
- clr after 5 operands, then 8 operands of 2 -> single result 16; no result from the aborted group. clr during WAIT -> no out_valid.
- rst_n asserted mid-WAIT (async, off clock edge) -> out_valid=0, leaf_ops=0 immediately; after release, a fresh group of 3s yields 24.
